// File: rtl/data_mem_sys_if.sv
// Core <-> data memory request/response bundle. Core holds i_read/i_write
// until o_done; o_err pulses alongside o_done on a rejected access.
interface data_mem_sys_if #(
  parameter int DATA_WIDTH = 8
);
  logic [15:0]           i_addr;
  logic [DATA_WIDTH-1:0] i_wdata;
  logic                  i_read;
  logic                  i_write;
  logic [DATA_WIDTH-1:0] o_rdata;
  logic                  o_done;
  logic                  o_err;
  logic [DATA_WIDTH-1:0] o_mem_view;

  modport master (
    output i_addr, i_wdata, i_read, i_write,
    input  o_rdata, o_done, o_err, o_mem_view
  );

  modport slave (
    input  i_addr, i_wdata, i_read, i_write,
    output o_rdata, o_done, o_err, o_mem_view
  );
endinterface

// File: rtl/data_mem_sys.sv
// Banked data memory behind the core RAM port.
// Address = {bank, word}; banks are independent arrays instantiated per bank.
// A request is latched in IDLE, held in BUSY for WAIT_STATES extra cycles,
// committed on the BUSY->DONE edge, then the FSM waits for the core to drop
// its request before accepting another.
// Optional feature macro: DATA_MEM_VIEW_EN -- adds a read-only view register
// at VIEW_ADDR holding the data of the last committed write.

// One storage bank: synchronous write, asynchronous read, no reset on contents.
module data_mem_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Storage write port
  always_ff @(posedge i_clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module data_mem_sys #(
  parameter int          DATA_WIDTH      = 8,
  parameter int          BANK_ADDR_WIDTH = 4,
  parameter int          NUM_BANKS       = 2,
  parameter int          WAIT_STATES     = 1,
  parameter logic [15:0] VIEW_ADDR       = 16'hFFF0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  data_mem_sys_if.slave  bus
);
  localparam int BSEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

  typedef struct packed {
    logic [15:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  rd;
    logic                  wr;
  } req_t;

  state_t                 state_q, state_d;
  req_t                   req_q;
  logic [3:0]             wait_cnt_q;
  logic                   accept, finish;
  logic [15:0]            bank_full;
  logic                   in_range, is_view, conflict;
  logic [BSEL_W-1:0]      bank_idx;
  logic [BANK_ADDR_WIDTH-1:0] word;
  logic                   do_write, do_read;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
  logic [DATA_WIDTH-1:0]  rd_word;
  logic [DATA_WIDTH-1:0]  rdata_q, view_q;
  logic                   done_q, err_q;

  assign accept = (state_q == IDLE) && (bus.i_read || bus.i_write);
  assign finish = (state_q == BUSY) && (wait_cnt_q == 4'(WAIT_STATES));

  // Decode works on the latched address so mid-access input changes are inert.
  assign bank_full = req_q.addr >> BANK_ADDR_WIDTH;
  assign in_range  = bank_full < 16'(NUM_BANKS);
  assign bank_idx  = bank_full[BSEL_W-1:0];
  assign word      = req_q.addr[BANK_ADDR_WIDTH-1:0];
  assign conflict  = req_q.rd && req_q.wr;
`ifdef DATA_MEM_VIEW_EN
  assign is_view   = (req_q.addr == VIEW_ADDR);
`else
  assign is_view   = 1'b0;
`endif

  // View address shadows any bank it might overlap; a conflicting request does nothing.
  assign do_write = finish && req_q.wr && !req_q.rd && in_range && !is_view;
  assign do_read  = finish && req_q.rd && !req_q.wr;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    data_mem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (BANK_ADDR_WIDTH)
    ) u_bank (
      .i_clk (i_clk),
      .we    (do_write && (bank_idx == BSEL_W'(b))),
      .addr  (word),
      .wdata (req_q.wdata),
      .rdata (bank_rdata[b])
    );
  end

  assign rd_word = in_range ? bank_rdata[bank_idx] : '0;

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.i_read || bus.i_write) state_d = BUSY;
      BUSY:    if (finish) state_d = DONE;
      DONE:    state_d = (bus.i_read || bus.i_write) ? RELEASE : IDLE;
      RELEASE: if (!bus.i_read && !bus.i_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Wait-state counter and request latch
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wait_cnt_q <= '0;
      req_q      <= '0;
    end else if (accept) begin
      wait_cnt_q <= '0;
      req_q      <= '{addr: bus.i_addr, wdata: bus.i_wdata, rd: bus.i_read, wr: bus.i_write};
    end else if ((state_q == BUSY) && !finish) begin
      wait_cnt_q <= wait_cnt_q + 4'd1;
    end
  end

  // Completion flags and read data, all updated on the commit edge
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= finish;
      err_q  <= finish && (conflict || (!in_range && !is_view));
      if (do_read) rdata_q <= is_view ? view_q : rd_word;
    end
  end

`ifdef DATA_MEM_VIEW_EN
  // Debug view tracks data of every committed storage write
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)        view_q <= '0;
    else if (do_write) view_q <= req_q.wdata;
  end
`else
  assign view_q = '0;
`endif

  assign bus.o_rdata    = rdata_q;
  assign bus.o_done     = done_q;
  assign bus.o_err      = err_q;
  assign bus.o_mem_view = view_q;
endmodule
